poly_result_readback: RTL and testbench
=======================================

Name: poly_result_readback

Overview:
- Read-side companion to the operand write path: captures the 24-bit Dilithium MAU results (poly_mau_o0/o1) on every poly_valid and buffers them in a small FIFO.
- Serves the results, a status word and a capture counter to the SASEBO-GIII host over the 16-bit local bus read path.
- Sits in the chip top beside the local-bus interface; the top muxes lbus_do using rd_hit.

Parameters:
- DEPTH, 8, FIFO entries (power of two, 2..16)
- BASE, 16'h0100, base of this block's local-bus address window

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- poly_valid  in  1  single-cycle result strobe from MAU
- poly_mau_o0  in  24  result 0
- poly_mau_o1  in  24  result 1
- lbus_a  in  16  registered local-bus address
- lbus_di  in  16  registered local-bus write data
- lbus_wrn  in  1  bus write strobe, active low
- lbus_rdn  in  1  bus read strobe, active low
- lbus_do  out  16  registered read data
- rd_hit  out  1  high while lbus_do holds data from this block
- fifo_empty  out  1  FIFO empty flag (LED/debug)
- overflow  out  1  sticky drop flag

Behaviour:
- Clock/reset: one clock clk; rst_n asynchronous, active low.
- Reset values: lbus_do=0, rd_hit=0, fifo_empty=1, overflow=0, count=0, pointers=0, capture_cnt=0, previous-strobe registers=1.
- Read detect: rd_fall = prev_rdn & ~lbus_rdn, sampled in cycle N. lbus_do and rd_hit update at the N+1 edge. Each bus read triggers exactly one action.
- Write detect: wr_rise = ~prev_wrn & lbus_wrn. Committed using the lbus_a/lbus_di values in that cycle.
- Address map (offsets from BASE):
  - 0x00 STATUS: {overflow, 7'b0, 3'b0, count[4:0]}
  - 0x02 R0_HI: {8'b0, head.o0[23:16]}
  - 0x04 R0_LO: head.o0[15:0]
  - 0x06 R1_HI: {8'b0, head.o1[23:16]}
  - 0x08 R1_LO: head.o1[15:0]; pops the head entry.
  - 0x0A CNT: capture_cnt[15:0]
  - 0x10 CTRL (write-only): bit0=1 clears the FIFO, overflow and capture_cnt.
- Read-address rules:
  - Non-matching read address: rd_hit=0 and lbus_do holds its previous value.
  - CTRL read returns 0 with rd_hit=1.
- Empty FIFO: data reads return 16'h0000 and no pop occurs.
- Capture: on poly_valid, {o1,o0} (48 bits) is pushed if not full. If full, the entry is dropped and overflow is set sticky.
- capture_cnt increments on every poly_valid, including drops, and wraps 0xFFFF->0x0000.
- Simultaneous events:
  - Push and pop in the same cycle: both take effect and count is unchanged. When full, this push is accepted, not dropped.
  - Clear with push or pop in the same cycle: clear wins, the push is discarded, and capture_cnt=0. Overflow stays clear.
  - Read of STATUS in the same cycle as a push returns the pre-push count.
- Pointers: wrap modulo DEPTH. count is 5 bits, range 0..DEPTH.
- Reset mid-transfer: all state returns to reset values immediately. The next bus access starts clean, since the previous-strobe registers are 1.
- Single FSM for the bus side:
  - IDLE: on rd_fall go to READ; on wr_rise go to WRITE.
  - READ: 1 cycle (drive lbus_do, pop if R1_LO), then WAIT_RDN.
  - WAIT_RDN: stay until lbus_rdn=1, then IDLE.
  - WRITE: 1 cycle (apply CTRL), then IDLE.
  - A read and a write seen in the same cycle is illegal; read takes priority.

Decomposition:
- Shared package holds:
  - address offset constants (STATUS, R0_HI, R0_LO, R1_HI, R1_LO, CNT, CTRL)
  - the 48-bit result entry typedef
  - the bus FSM state enum
  - DEPTH default
- One sub-module is natural: result_fifo (sync FIFO, 48-bit, DEPTH entries, push/pop/clear, count/full/empty, clear priority). Bus decode and FSM stay in the top.

Test Plan:
- Basic readback: reset, then one poly_valid with o0=24'h12_3456, o1=24'hAB_CDEF. Read STATUS -> 16'h0001. Reads of R0_HI/R0_LO/R1_HI/R1_LO -> 0x0012, 0x3456, 0x00AB, 0xCDEF. STATUS -> 0x0000 and fifo_empty=1.
- Overflow: 9 poly_valid pulses with o0=1..9, DEPTH=8. STATUS -> 0x8008 and CNT -> 0x0009. Draining 8 entries yields o0=1..8 in order; entry 9 is lost.
- Empty read: read R1_LO with FIFO empty -> 0x0000, rd_hit=1, count stays 0, no pointer change.
- Concurrent push/pop when full: FIFO full, poly_valid coincident with the R1_LO pop cycle -> count stays 8, overflow stays 0, and the new entry drains last.
- Clear race: write CTRL=0x0001 with its commit cycle coincident with poly_valid -> STATUS=0x0000, CNT=0x0000.
- Async reset: assert rst_n low while in WAIT_RDN with lbus_rdn low -> lbus_do=0 and rd_hit=0 immediately. After release, with lbus_rdn still low, no read is triggered; the next high->low edge reads normally.

Source files
------------

// File: rtl/poly_result_readback_pkg.sv
// Shared definitions for the MAU result readback block: bus offsets,
// the buffered result entry and the bus-side FSM states.
package poly_result_readback_pkg;

  localparam int DEPTH_DEFAULT = 8;

  localparam logic [15:0] OFF_STATUS = 16'h0000;
  localparam logic [15:0] OFF_R0_HI  = 16'h0002;
  localparam logic [15:0] OFF_R0_LO  = 16'h0004;
  localparam logic [15:0] OFF_R1_HI  = 16'h0006;
  localparam logic [15:0] OFF_R1_LO  = 16'h0008;
  localparam logic [15:0] OFF_CNT    = 16'h000A;
  localparam logic [15:0] OFF_CTRL   = 16'h0010;

  // One captured MAU result pair, o1 in the upper half.
  typedef struct packed {
    logic [23:0] o1;
    logic [23:0] o0;
  } result_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT_RDN,
    ST_WRITE
  } bus_state_e;

  // Upper byte of a 24-bit result, zero-extended onto the 16-bit bus.
  function automatic logic [15:0] hi_word(input logic [23:0] v);
    return {8'h00, v[23:16]};
  endfunction

endpackage

// File: rtl/poly_result_readback_fifo.sv
// Synchronous result FIFO: 48-bit entries, push/pop/clear with clear
// taking priority, and a push into a full FIFO accepted only when a pop
// frees a slot in the same cycle.
module poly_result_readback_fifo
  import poly_result_readback_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  result_entry_t data_i,
  output result_entry_t head_o,
  output logic [4:0]    count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH);

  result_entry_t mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == 5'(DEPTH));
  assign empty_o = (count_q == 5'd0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o & ~clear_i;
  assign push_ok = push_i & ~clear_i & (~full_o | pop_ok);

  // Next pointer and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + 5'(push_ok) - 5'(pop_ok);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/poly_result_readback.sv
// Local-bus read side for the Dilithium MAU: captures result pairs into a
// FIFO and serves them, a status word and a capture counter to the host.
module poly_result_readback
  import poly_result_readback_pkg::*;
#(
  parameter int          DEPTH = DEPTH_DEFAULT,
  parameter logic [15:0] BASE  = 16'h0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        poly_valid,
  input  logic [23:0] poly_mau_o0,
  input  logic [23:0] poly_mau_o1,
  input  logic [15:0] lbus_a,
  input  logic [15:0] lbus_di,
  input  logic        lbus_wrn,
  input  logic        lbus_rdn,
  output logic [15:0] lbus_do,
  output logic        rd_hit,
  output logic        fifo_empty,
  output logic        overflow
);

  localparam logic [15:0] A_STATUS = BASE + OFF_STATUS;
  localparam logic [15:0] A_R0_HI  = BASE + OFF_R0_HI;
  localparam logic [15:0] A_R0_LO  = BASE + OFF_R0_LO;
  localparam logic [15:0] A_R1_HI  = BASE + OFF_R1_HI;
  localparam logic [15:0] A_R1_LO  = BASE + OFF_R1_LO;
  localparam logic [15:0] A_CNT    = BASE + OFF_CNT;
  localparam logic [15:0] A_CTRL   = BASE + OFF_CTRL;

  bus_state_e    state_q, state_d;
  logic          prev_rdn_q, prev_wrn_q;
  logic          rd_fall, wr_rise;
  logic [15:0]   addr_q, wdata_q;
  logic [15:0]   lbus_do_q, lbus_do_d;
  logic          rd_hit_q, rd_hit_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   capture_cnt_q, capture_cnt_d;
  logic          pop, clear;
  result_entry_t entry_in, head, head_rd;
  logic [4:0]    fifo_count;
  logic          fifo_full;

  assign rd_fall = prev_rdn_q & ~lbus_rdn;
  assign wr_rise = ~prev_wrn_q & lbus_wrn;

  assign entry_in = '{o1: poly_mau_o1, o0: poly_mau_o0};
  assign head_rd  = fifo_empty ? '0 : head;

  assign lbus_do  = lbus_do_q;
  assign rd_hit   = rd_hit_q;
  assign overflow = overflow_q;

  poly_result_readback_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (poly_valid),
    .pop_i  (pop),
    .clear_i(clear),
    .data_i (entry_in),
    .head_o (head),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Bus FSM state register; reset lands in WAIT_RDN so a strobe still held low across reset is never taken as a new read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_WAIT_RDN;
    else        state_q <= state_d;
  end

  // Bus FSM transitions; a read wins over a write seen in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_fall)      state_d = ST_READ;
        else if (wr_rise) state_d = ST_WRITE;
      end
      ST_READ:     state_d = ST_WAIT_RDN;
      ST_WAIT_RDN: if (lbus_rdn) state_d = ST_IDLE;
      ST_WRITE:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Bus FSM outputs: read decode with pop on R1_LO, and CTRL clear on write commit.
  always_comb begin
    lbus_do_d = lbus_do_q;
    rd_hit_d  = rd_hit_q;
    pop       = 1'b0;
    clear     = 1'b0;
    unique case (state_q)
      ST_READ: begin
        rd_hit_d = 1'b1;
        case (addr_q)
          A_STATUS: lbus_do_d = {overflow_q, 7'b0, 3'b0, fifo_count};
          A_R0_HI:  lbus_do_d = hi_word(head_rd.o0);
          A_R0_LO:  lbus_do_d = head_rd.o0[15:0];
          A_R1_HI:  lbus_do_d = hi_word(head_rd.o1);
          A_R1_LO: begin
            lbus_do_d = head_rd.o1[15:0];
            pop       = 1'b1;
          end
          A_CNT:    lbus_do_d = capture_cnt_q;
          A_CTRL:   lbus_do_d = 16'h0000;
          default:  rd_hit_d  = 1'b0;
        endcase
      end
      ST_WRITE: begin
        if (addr_q == A_CTRL && wdata_q[0]) clear = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture counter and sticky overflow; clear overrides any same-cycle capture.
  always_comb begin
    capture_cnt_d = capture_cnt_q;
    overflow_d    = overflow_q;
    if (clear) begin
      capture_cnt_d = '0;
      overflow_d    = 1'b0;
    end else if (poly_valid) begin
      capture_cnt_d = capture_cnt_q + 16'd1;
      if (fifo_full && !(pop && !fifo_empty)) overflow_d = 1'b1;
    end
  end

  // Strobe history, latched bus access, read data and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_rdn_q    <= 1'b1;
      prev_wrn_q    <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      lbus_do_q     <= '0;
      rd_hit_q      <= 1'b0;
      overflow_q    <= 1'b0;
      capture_cnt_q <= '0;
    end else begin
      prev_rdn_q <= lbus_rdn;
      prev_wrn_q <= lbus_wrn;
      if (state_q == ST_IDLE && (rd_fall || wr_rise)) begin
        addr_q  <= lbus_a;
        wdata_q <= lbus_di;
      end
      lbus_do_q     <= lbus_do_d;
      rd_hit_q      <= rd_hit_d;
      overflow_q    <= overflow_d;
      capture_cnt_q <= capture_cnt_d;
    end
  end

endmodule

// File: tb/tb_poly_result_readback.sv
// Self-checking bench for poly_result_readback: a queue-based model of the
// result buffer predicts every bus read, including randomized traffic.
module tb_poly_result_readback;

  localparam int          DEPTH = 8;
  localparam logic [15:0] BASE  = 16'h0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        poly_valid = 1'b0;
  logic [23:0] poly_mau_o0 = '0;
  logic [23:0] poly_mau_o1 = '0;
  logic [15:0] lbus_a = '0;
  logic [15:0] lbus_di = '0;
  logic        lbus_wrn = 1'b1;
  logic        lbus_rdn = 1'b1;
  logic [15:0] lbus_do;
  logic        rd_hit;
  logic        fifo_empty;
  logic        overflow;

  int checks = 0;
  int passed = 0;

  logic [47:0] mq[$];
  logic        m_ovf;
  logic [15:0] m_cnt;
  logic [15:0] m_do;
  logic        m_hit;

  poly_result_readback #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .poly_valid (poly_valid),
    .poly_mau_o0(poly_mau_o0),
    .poly_mau_o1(poly_mau_o1),
    .lbus_a     (lbus_a),
    .lbus_di    (lbus_di),
    .lbus_wrn   (lbus_wrn),
    .lbus_rdn   (lbus_rdn),
    .lbus_do    (lbus_do),
    .rd_hit     (rd_hit),
    .fifo_empty (fifo_empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_cnt = '0;
    m_do  = '0;
    m_hit = 1'b0;
  endfunction

  function automatic void model_capture(input logic [23:0] a0, input logic [23:0] a1);
    m_cnt = m_cnt + 16'd1;
    if (mq.size() < DEPTH) mq.push_back({a1, a0});
    else m_ovf = 1'b1;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] addr);
    logic [47:0] h;
    h = (mq.size() > 0) ? mq[0] : 48'h0;
    m_hit = 1'b1;
    case (addr - BASE)
      16'h0000: m_do = {m_ovf, 10'b0, 5'(mq.size())};
      16'h0002: m_do = {8'h00, h[23:16]};
      16'h0004: m_do = h[15:0];
      16'h0006: m_do = {8'h00, h[47:40]};
      16'h0008: begin
        m_do = h[39:24];
        if (mq.size() > 0) void'(mq.pop_front());
      end
      16'h000A: m_do = m_cnt;
      16'h0010: m_do = 16'h0000;
      default:  m_hit = 1'b0;
    endcase
    return m_do;
  endfunction

  function automatic void model_write(input logic [15:0] addr, input logic [15:0] data,
                                      input bit co, input logic [23:0] c0, input logic [23:0] c1);
    if (addr == BASE + 16'h0010 && data[0]) begin
      mq.delete();
      m_ovf = 1'b0;
      m_cnt = '0;
    end else if (co) begin
      model_capture(c0, c1);
    end
  endfunction

  task automatic pulse(input logic [23:0] c0, input logic [23:0] c1);
    model_capture(c0, c1);
    @(negedge clk);
    poly_valid  = 1'b1;
    poly_mau_o0 = c0;
    poly_mau_o1 = c1;
    @(negedge clk);
    poly_valid = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, input bit co, input logic [23:0] c0,
                          input logic [23:0] c1, output logic [15:0] d, output logic h,
                          output logic [15:0] ed, output logic eh);
    ed = model_read(addr);
    eh = m_hit;
    if (co) model_capture(c0, c1);
    @(negedge clk);
    lbus_a   = addr;
    lbus_rdn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (co) begin
      poly_valid  = 1'b1;
      poly_mau_o0 = c0;
      poly_mau_o1 = c1;
    end
    @(posedge clk);
    @(negedge clk);
    poly_valid = 1'b0;
    d = lbus_do;
    h = rd_hit;
    lbus_rdn = 1'b1;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data, input bit co,
                           input logic [23:0] c0, input logic [23:0] c1);
    model_write(addr, data, co, c0, c1);
    @(negedge clk);
    lbus_a   = addr;
    lbus_di  = data;
    lbus_wrn = 1'b0;
    @(negedge clk);
    lbus_wrn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (co) begin
      poly_valid  = 1'b1;
      poly_mau_o0 = c0;
      poly_mau_o1 = c1;
    end
    @(posedge clk);
    @(negedge clk);
    poly_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] d, ed;
    logic h, eh;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (lbus_do !== 16'h0000) $display("[TB] FAIL reset_do: got %h expected 0000", lbus_do); else passed++;
    checks++; if (rd_hit !== 1'b0) $display("[TB] FAIL reset_hit: got %b expected 0", rd_hit); else passed++;
    checks++; if (fifo_empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", fifo_empty); else passed++;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_ovf: got %b expected 0", overflow); else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(BASE + 16'h000A, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h0000 || h !== 1'b1) $display("[TB] FAIL reset_cnt: got %h/%b expected 0000/1", d, h); else passed++;
  endtask

  task automatic test_basic();
    logic [15:0] d, ed;
    logic h, eh;
    pulse(24'h123456, 24'hABCDEF);
    bus_read(BASE + 16'h0000, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h0001 || h !== 1'b1) $display("[TB] FAIL basic_status: got %h/%b expected 0001/1", d, h); else passed++;
    bus_read(BASE + 16'h0002, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h0012) $display("[TB] FAIL basic_r0_hi: got %h expected 0012", d); else passed++;
    bus_read(BASE + 16'h0004, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h3456) $display("[TB] FAIL basic_r0_lo: got %h expected 3456", d); else passed++;
    bus_read(BASE + 16'h0006, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h00AB) $display("[TB] FAIL basic_r1_hi: got %h expected 00ab", d); else passed++;
    bus_read(BASE + 16'h0008, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'hCDEF) $display("[TB] FAIL basic_r1_lo: got %h expected cdef", d); else passed++;
    bus_read(BASE + 16'h0000, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h0000) $display("[TB] FAIL basic_status_after: got %h expected 0000", d); else passed++;
    checks++; if (fifo_empty !== 1'b1) $display("[TB] FAIL basic_empty: got %b expected 1", fifo_empty); else passed++;
  endtask

  task automatic test_overflow();
    logic [15:0] d, ed;
    logic h, eh;
    bus_write(BASE + 16'h0010, 16'h0001, 1'b0, '0, '0);
    for (int i = 1; i <= 9; i++) pulse(24'(i), 24'($urandom));
    bus_read(BASE + 16'h0000, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h8008) $display("[TB] FAIL ovf_status: got %h expected 8008", d); else passed++;
    bus_read(BASE + 16'h000A, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h0009) $display("[TB] FAIL ovf_cnt: got %h expected 0009", d); else passed++;
    checks++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_pin: got %b expected 1", overflow); else passed++;
    for (int i = 1; i <= 8; i++) begin
      bus_read(BASE + 16'h0004, 1'b0, '0, '0, d, h, ed, eh);
      checks++; if (d !== 16'(i)) $display("[TB] FAIL ovf_drain_o0: got %h expected %h", d, 16'(i)); else passed++;
      bus_read(BASE + 16'h0008, 1'b0, '0, '0, d, h, ed, eh);
      checks++; if (d !== ed) $display("[TB] FAIL ovf_drain_o1: got %h expected %h", d, ed); else passed++;
    end
    bus_read(BASE + 16'h0000, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h8000) $display("[TB] FAIL ovf_status_drained: got %h expected 8000", d); else passed++;
  endtask

  task automatic test_empty_read();
    logic [15:0] d, ed;
    logic h, eh;
    bus_read(BASE + 16'h0008, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h0000 || h !== 1'b1) $display("[TB] FAIL empty_r1_lo: got %h/%b expected 0000/1", d, h); else passed++;
    bus_read(BASE + 16'h0000, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h8000) $display("[TB] FAIL empty_status: got %h expected 8000", d); else passed++;
    pulse(24'h000077, 24'h00BEEF);
    bus_read(BASE + 16'h0008, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'hBEEF) $display("[TB] FAIL empty_no_ptr_move: got %h expected beef", d); else passed++;
    bus_write(BASE + 16'h0010, 16'h0001, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL clear_ovf: got %b expected 0", overflow); else passed++;
  endtask

  task automatic test_random();
    logic [15:0] d, ed, addr;
    logic h, eh;
    logic [15:0] offs [10];
    int pick;
    offs = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h000A, 16'h0010, 16'h000C, 16'h0012, 16'h0001};
    for (int it = 0; it < 120; it++) begin
      pick = $urandom_range(0, 9);
      if (pick < 4) begin
        pulse(24'($urandom), 24'($urandom));
      end else if (pick < 9) begin
        if ($urandom_range(0, 9) < 8) addr = BASE + offs[$urandom_range(0, 9)];
        else addr = 16'($urandom);
        bus_read(addr, ($urandom_range(0, 3) == 0), 24'($urandom), 24'($urandom), d, h, ed, eh);
        checks++; if (d !== ed || h !== eh) $display("[TB] FAIL rand_read@%h: got %h/%b expected %h/%b", addr, d, h, ed, eh); else passed++;
      end else begin
        addr = ($urandom_range(0, 1) == 0) ? BASE + 16'h0010 : BASE + 16'h0008;
        bus_write(addr, 16'($urandom_range(0, 3)), 1'b0, '0, '0);
      end
      @(negedge clk);
      checks++; if (fifo_empty !== (mq.size() == 0) || overflow !== m_ovf) $display("[TB] FAIL rand_flags: got %b/%b expected %b/%b", fifo_empty, overflow, (mq.size() == 0), m_ovf); else passed++;
    end
    bus_write(BASE + 16'h0010, 16'h0001, 1'b0, '0, '0);
  endtask

  task automatic test_push_pop_full();
    logic [15:0] d, ed;
    logic h, eh;
    logic [23:0] nv0, nv1;
    for (int i = 0; i < DEPTH; i++) pulse(24'($urandom), 24'($urandom));
    nv0 = 24'($urandom);
    nv1 = 24'($urandom);
    bus_read(BASE + 16'h0008, 1'b1, nv0, nv1, d, h, ed, eh);
    checks++; if (d !== ed) $display("[TB] FAIL full_pop_data: got %h expected %h", d, ed); else passed++;
    bus_read(BASE + 16'h0000, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h0008) $display("[TB] FAIL full_push_pop_status: got %h expected 0008", d); else passed++;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL full_push_pop_ovf: got %b expected 0", overflow); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(BASE + 16'h0004, 1'b0, '0, '0, d, h, ed, eh);
      if (i == DEPTH - 1) begin
        checks++; if (d !== nv0[15:0]) $display("[TB] FAIL full_last_entry: got %h expected %h", d, nv0[15:0]); else passed++;
      end
      bus_read(BASE + 16'h0008, 1'b0, '0, '0, d, h, ed, eh);
      checks++; if (d !== ed) $display("[TB] FAIL full_drain: got %h expected %h", d, ed); else passed++;
    end
  endtask

  task automatic test_clear_race();
    logic [15:0] d, ed;
    logic h, eh;
    for (int i = 0; i < 3; i++) pulse(24'($urandom), 24'($urandom));
    bus_write(BASE + 16'h0010, 16'h0001, 1'b1, 24'h111111, 24'h222222);
    bus_read(BASE + 16'h0000, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h0000) $display("[TB] FAIL clear_race_status: got %h expected 0000", d); else passed++;
    bus_read(BASE + 16'h000A, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h0000) $display("[TB] FAIL clear_race_cnt: got %h expected 0000", d); else passed++;
    bus_write(BASE + 16'h0010, 16'h0002, 1'b1, 24'h333333, 24'h444444);
    bus_read(BASE + 16'h0000, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h0001) $display("[TB] FAIL noclear_status: got %h expected 0001", d); else passed++;
    bus_read(BASE + 16'h000A, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h0001) $display("[TB] FAIL noclear_cnt: got %h expected 0001", d); else passed++;
  endtask

  task automatic test_async_reset();
    logic [15:0] d, ed;
    logic h, eh;
    pulse(24'h00ABCD, 24'h001234);
    ed = model_read(BASE + 16'h000A);
    @(negedge clk);
    lbus_a   = BASE + 16'h000A;
    lbus_rdn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++; if (lbus_do !== ed || rd_hit !== 1'b1) $display("[TB] FAIL pre_reset_read: got %h/%b expected %h/1", lbus_do, rd_hit, ed); else passed++;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (lbus_do !== 16'h0000 || rd_hit !== 1'b0) $display("[TB] FAIL async_reset_out: got %h/%b expected 0000/0", lbus_do, rd_hit); else passed++;
    checks++; if (fifo_empty !== 1'b1 || overflow !== 1'b0) $display("[TB] FAIL async_reset_flags: got %b/%b expected 1/0", fifo_empty, overflow); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rd_hit !== 1'b0 || lbus_do !== 16'h0000) $display("[TB] FAIL held_rdn_no_read: got %h/%b expected 0000/0", lbus_do, rd_hit); else passed++;
    lbus_rdn = 1'b1;
    repeat (2) @(negedge clk);
    pulse(24'h000001, 24'h000002);
    bus_read(BASE + 16'h0000, 1'b0, '0, '0, d, h, ed, eh);
    checks++; if (d !== 16'h0001 || h !== 1'b1) $display("[TB] FAIL post_reset_read: got %h/%b expected 0001/1", d, h); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_empty_read();
    test_random();
    test_push_pop_full();
    test_clear_race();
    test_async_reset();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
